// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its queue.
// FETCH_ALIGN_TRAP_EN (see instr_fetch_unit) selects whether StFault is ever entered.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFault
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of fetched {pc, instr} entries.
// Flush wins over push; the head is visible combinationally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_empty,
  output logic         o_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner and fetch initiator feeding decode through a small queue.
// Define FETCH_ALIGN_TRAP_EN to trap misaligned redirects (adds fetch_fault and StFault).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
`ifdef FETCH_ALIGN_TRAP_EN
  output logic        fetch_fault,
`endif
  output logic [31:0] out_pc
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;

  logic         w_empty;
  logic         w_full;
  logic         w_pop;
  logic         w_fetch;
  logic         w_redirect;
  logic [31:0]  w_redir_pc;
  fetch_entry_t w_head;
  fetch_entry_t w_push_data;

`ifdef FETCH_ALIGN_TRAP_EN
  logic r_fault;
  logic w_misaligned;

  assign w_redir_pc   = redirect_pc;
  assign w_misaligned = |redirect_pc[1:0];
  assign fetch_fault  = r_fault;
`else
  assign w_redir_pc = redirect_pc & ~32'h0000_0003;
`endif

  assign w_redirect  = redirect_valid && (r_state != StIdle);
  assign w_pop       = !w_empty && out_ready;
  // Space check looks past this cycle's dequeue so a full queue streams at one per cycle.
  assign w_fetch     = (r_state == StRun) && !redirect_valid && (!w_full || w_pop);
  assign w_push_data = '{pc: r_pc, instr: imem_instr};

  assign imem_req  = w_fetch;
  assign imem_addr = r_pc;
  assign out_valid = !w_empty;
  assign out_instr = w_empty ? NOP_INSTR : w_head.instr;
  assign out_pc    = w_empty ? 32'h0 : w_head.pc;

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_fetch),
    .i_push_data(w_push_data),
    .i_pop      (w_pop),
    .i_flush    (w_redirect),
    .o_head     (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_pc    <= RESET_PC;
`ifdef FETCH_ALIGN_TRAP_EN
      r_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: r_state <= StRun;
        default: begin
          if (redirect_valid) begin
            r_pc <= w_redir_pc;
`ifdef FETCH_ALIGN_TRAP_EN
            r_state <= w_misaligned ? StFault : StRun;
            r_fault <= w_misaligned;
`endif
          end else if (w_fetch) begin
            r_pc <= r_pc + PC_INC;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed phases push expected {pc, instr}
// handshakes, a negedge monitor pops and compares them.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_ALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  logic [31:0] mem [1024];
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;

  assign imem_instr = mem[imem_addr[11:2]];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
`ifdef FETCH_ALIGN_TRAP_EN
    .fetch_fault   (fetch_fault),
`endif
    .out_pc        (out_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem[pc[11:2]];
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Keep out_ready high until every expected handshake has been seen, then drop it.
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual %0d required 0 pending", sb.size());
      sb.delete();
    end
    out_ready = 1'b0;
  endtask

  // Ends at the negedge of cycle 2, when the first fetched instruction is presented.
  task automatic restart();
    rst = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_out_instr", out_instr, 32'h0000_0013);
    check("rst_out_pc", out_pc, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("c0_imem_req", 32'(imem_req), 32'd0);
    check("c0_out_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check("c1_imem_req", 32'(imem_req), 32'd1);
    check("c1_imem_addr", imem_addr, 32'h0);
    check("c1_out_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check("c2_out_valid", 32'(out_valid), 32'd1);
    check("c2_out_pc", out_pc, 32'h0);
    check("c2_out_instr", out_instr, 32'h0050_0093);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL hs_unexpected actual pc %h required no handshake", out_pc);
      end else begin
        e = sb.pop_front();
        check("hs_pc", out_pc, e.pc);
        check("hs_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | 32'(i);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00a0_0113;
    mem[2] = 32'h0020_81b3;

    // Reset and stream
    out_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    restart();
    drain();

    // Backpressure
    out_ready = 1'b0;
    restart();
    check("bp_c2_imem_addr", imem_addr, 32'h4);
    step(); @(negedge clk);
    check("bp_c3_imem_req", 32'(imem_req), 32'd0);
    check("bp_c3_imem_addr", imem_addr, 32'h8);
    step(); @(negedge clk);
    check("bp_c4_imem_req", 32'(imem_req), 32'd0);
    check("bp_c4_out_pc", out_pc, 32'h0);
    step();
    out_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    @(negedge clk);
    check("bp_c5_imem_req", 32'(imem_req), 32'd1);
    check("bp_c5_imem_addr", imem_addr, 32'h8);
    drain();

    // Redirect while the queue holds 0x8/0xC
    restart();
    step();
    out_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4);
    step();
    step();
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    check("rd_head_before", out_pc, 32'h8);
    check("rd_imem_req", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    expect_pc(32'h40); expect_pc(32'h44);
    @(negedge clk);
    check("rd_n1_out_valid", 32'(out_valid), 32'd0);
    check("rd_n1_imem_req", 32'(imem_req), 32'd1);
    check("rd_n1_imem_addr", imem_addr, 32'h40);
    step(); @(negedge clk);
    check("rd_n2_out_pc", out_pc, 32'h40);
    drain();

    // Wrap
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    expect_pc(32'hFFFF_FFF8); expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
    @(negedge clk);
    check("wrap_imem_addr", imem_addr, 32'hFFFF_FFF8);
    check("wrap_out_valid", 32'(out_valid), 32'd0);
    drain();

    // Redirect coincident with a head handshake (queue holds 0x4/0x8)
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    out_ready = 1'b1;
    expect_pc(32'h4);
    @(negedge clk);
    check("sim_head_pc", out_pc, 32'h4);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("sim_empty_after", 32'(out_valid), 32'd0);
    check("sim_imem_addr", imem_addr, 32'h80);
    expect_pc(32'h80); expect_pc(32'h84);
    drain();

    // Asynchronous reset pulse mid-cycle
    check("arst_valid_before", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_imem_req", 32'(imem_req), 32'd0);
    check("arst_out_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    restart();
    drain();

    // Misaligned redirect
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_TRAP_EN
    @(negedge clk);
    check("mis_fault", 32'(fetch_fault), 32'd1);
    check("mis_imem_req", 32'(imem_req), 32'd0);
    check("mis_imem_addr", imem_addr, 32'h42);
    check("mis_out_valid", 32'(out_valid), 32'd0);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h46;
    @(negedge clk);
    check("mis_hold_req", 32'(imem_req), 32'd0);
    step();
    redirect_pc = 32'h44;
    @(negedge clk);
    check("mis_still_fault", 32'(fetch_fault), 32'd1);
    check("mis_still_req", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mis_clear_fault", 32'(fetch_fault), 32'd0);
    check("mis_restart_req", 32'(imem_req), 32'd1);
    check("mis_restart_addr", imem_addr, 32'h44);
    expect_pc(32'h44);
    drain();
`else
    out_ready = 1'b1;
    @(negedge clk);
    check("mis_imem_req", 32'(imem_req), 32'd1);
    check("mis_imem_addr", imem_addr, 32'h40);
    check("mis_out_valid", 32'(out_valid), 32'd0);
    expect_pc(32'h40); expect_pc(32'h44);
    drain();
`endif

    check("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch-side initiator for the CPU core's instruction memory. It owns the program counter and drives word addresses into the combinational instruction memory. It captures the returned instruction with its PC into a small queue and presents them to decode over a valid/ready handshake. Decode or execute can redirect the PC with a redirect request, which flushes all queued instructions.

## Interface
- `RESET_PC`, 32'h0000_0000, first PC fetched after reset.
- `QUEUE_DEPTH`, 2, fetch queue entries; power of two, 2..8.
- `NOP_INSTR`, 32'h0000_0013, value driven on `out_instr` when the queue is empty.

Ports:
- `clk` in 1, single clock.
- `rst` in 1, asynchronous, active-high reset.
- `imem_addr` out 32, byte address to instruction memory (memory indexes `[11:2]`).
- `imem_req` out 1, `imem_addr` is a live fetch this cycle.
- `imem_instr` in 32, instruction returned combinationally for `imem_addr`.
- `redirect_valid` in 1, load a new PC and flush the queue.
- `redirect_pc` in 32, redirect target.
- `out_valid` out 1, the queue head is valid.
- `out_ready` in 1, decode accepts the head.
- `out_instr` out 32, instruction at the queue head.
- `out_pc` out 32, PC of the queue head.
- `fetch_fault` out 1, misaligned redirect trap. Exists only with `FETCH_ALIGN_TRAP_EN`.

## Operation
- States: IDLE, RUN, and FAULT (FAULT only with the macro).
- IDLE → RUN: unconditionally, on the first clock after reset deasserts.
- RUN behaviour:
  - A fetch is issued when `!redirect_valid` and the queue has space after this cycle's dequeue (`count < QUEUE_DEPTH` or the head is being popped).
  - On a fetch: `imem_req`=1, `imem_addr`=`pc`, `{pc, imem_instr}` is enqueued at the clock edge, and `pc` advances by 4.
- Queue full with no pop: `imem_req`=0, `imem_addr` holds `pc`, and `pc` holds.
- PC arithmetic: 32-bit modulo, so 32'hFFFF_FFFC + 4 = 32'h0000_0000. There is no fault on wrap.
- Dequeue: occurs when `out_valid && out_ready`. The head is popped at the edge.
- Redirect (any state except IDLE) has priority over fetch:
  - No fetch is issued that cycle.
  - Queue count is cleared.
  - `pc` ← `redirect_pc`.
  - A dequeue in the same cycle still counts as consumed, but the queue is empty afterwards regardless.
- `redirect_valid` during IDLE is ignored.
- `out_instr`/`out_pc` show the head entry when `out_valid`. Otherwise they show `NOP_INSTR` / 32'h0.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state=IDLE, count=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `out_valid`=0, `out_instr`=`NOP_INSTR`, `out_pc`=0, `fetch_fault`=0.
- Reset is asynchronous and may assert mid-stream. All queued entries are discarded immediately.
- Fetch latency: an instruction fetched in cycle N is visible with `out_valid`=1 in cycle N+1.
- First fetch after reset release: occurs in cycle 1 (cycle 0 is IDLE), so `out_valid` first rises in cycle 2.
- Redirect asserted in cycle N:
  - Cycle N+1 fetches `redirect_pc`.
  - The target instruction is presented in cycle N+2.
  - `out_valid`=0 in cycle N+1.
- Sustained throughput with `out_ready` held at 1: one instruction per cycle.
- `out_valid` does not depend combinationally on `out_ready`.

## Configuration
- Macro: `FETCH_ALIGN_TRAP_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0]`≠0 enters FAULT at the edge.
  - `fetch_fault`=1 from the next cycle, and `pc` ← `redirect_pc`.
  - No fetches are issued and the queue is empty.
  - Only a subsequent aligned redirect returns the unit to RUN (and clears `fault`). A misaligned redirect keeps it in FAULT.
- Not defined:
  - `redirect_pc[1:0]` is forced to 0 and there is no FAULT state.
  - The `fetch_fault` port is absent.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (IDLE/RUN/FAULT);
  - the `NOP_INSTR` and `RESET_PC` defaults;
  - the PC increment constant 4;
  - the queue entry struct `{pc[31:0], instr[31:0]}`.
- Sub-module `fetch_queue`: a synchronous FIFO of entries with push, pop and a flush port. Flush has priority over push. It is asynchronous-reset and gives combinational head visibility.

## Test plan
- **Reset and stream:** default params, memory holding 0x00500093, 0x00a00113, 0x002081b3, `out_ready`=1 → `out_pc` sequence 0,4,8 in cycles 2,3,4 with the matching instructions.
- **Backpressure:** `out_ready`=0 from cycle 2 → queue fills with PCs 0,4, and `imem_req`=0 from cycle 3. Raising `out_ready` drains 0,4,8 with no gaps or duplicates.
- **Redirect:** redirect to 0x40 while the queue holds 0x8/0xC → the next presented PC is 0x40 two cycles later. 0x8/0xC never appear after the redirect edge.
- **Wrap:** redirect to 32'hFFFF_FFF8 → `out_pc` runs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Simultaneous events:** redirect coincident with a head handshake → the handshake is consumed exactly once, then the queue is empty. Async `rst` pulse mid-stream → `out_valid`=0 immediately, then the restart timing repeats.
- **Misaligned redirect:** redirect to 0x42 → with `FETCH_ALIGN_TRAP_EN`, `fetch_fault`=1 and no fetches until a redirect to 0x44 restarts at 0x44. Without the macro, fetch resumes at 0x40.
